// File: rtl/spi_fsm.sv
// SPI slave control FSM: sequences address capture, read/write decode and data
// transfer; every output is decoded from the state register alone.
module spi_fsm #(
   parameter int WORD_BITS = 8,
   parameter int CNT_W     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk_pos,
   input  logic       sclk_neg,
   input  logic       cs,
   input  logic       rw_bit,
   output logic       miso_buff,
   output logic       dm_we,
   output logic       addr_we,
   output logic       sr_we,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      GET_ADDR    = 4'd1,
      GOT_ADDR    = 4'd2,
      DECODE      = 4'd3,
      READ_WAIT   = 4'd4,
      READ_LOAD   = 4'd5,
      READ_SHIFT  = 4'd6,
      WRITE_GET   = 4'd7,
      WRITE_STORE = 4'd8,
      DONE        = 4'd9
   } state_e;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BITS - 1);

   // Plain vector so that codes 10-15 are representable and recoverable
   logic [3:0]       state_q;
   state_e           state_n;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
      end
   end

   always_comb begin
      state_n = IDLE;
      cnt_n   = cnt_q;
      case (state_q)
         IDLE: begin
            state_n = cs ? IDLE : GET_ADDR;
            cnt_n   = '0;
         end
         GET_ADDR: begin
            state_n = GET_ADDR;
            if (sclk_pos) begin
               if (cnt_q == LAST) begin
                  state_n = GOT_ADDR;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_q + 1'b1;
               end
            end
         end
         GOT_ADDR:  state_n = DECODE;
         DECODE: begin
            state_n = rw_bit ? READ_WAIT : WRITE_GET;
            cnt_n   = '0;
         end
         READ_WAIT: state_n = READ_LOAD;
         READ_LOAD: begin
            state_n = READ_SHIFT;
            cnt_n   = '0;
         end
         // Read data leaves on falling SCLK edges, write data arrives on rising ones
         READ_SHIFT: begin
            state_n = READ_SHIFT;
            if (sclk_neg) begin
               if (cnt_q == LAST) begin
                  state_n = DONE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_q + 1'b1;
               end
            end
         end
         WRITE_GET: begin
            state_n = WRITE_GET;
            if (sclk_pos) begin
               if (cnt_q == LAST) begin
                  state_n = WRITE_STORE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_q + 1'b1;
               end
            end
         end
         WRITE_STORE: state_n = DONE;
         DONE:        state_n = DONE;
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
      if (cs) begin
         state_n = IDLE;
         cnt_n   = '0;
      end
   end

   always_comb begin
      addr_we   = (state_q == GOT_ADDR);
      sr_we     = (state_q == READ_LOAD);
      miso_buff = (state_q == READ_SHIFT);
      dm_we     = (state_q == WRITE_STORE);
      state     = state_q;
   end

endmodule

// File: tb/tb_spi_fsm.sv
// Directed bench for spi_fsm: state transitions are scoreboarded, enable pulses
// are counted per clock, and edge/boundary behaviour is checked inline.
module tb_spi_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk_pos = 1'b0;
   logic       sclk_neg = 1'b0;
   logic       cs = 1'b1;
   logic       rw_bit = 1'b0;
   logic       miso_buff;
   logic       dm_we;
   logic       addr_we;
   logic       sr_we;
   logic [3:0] state;

   int         total = 0;
   int         bad = 0;
   int         exp_q[$];
   logic [3:0] prev_state = 4'd0;
   bit         mon_en = 1'b0;
   int         n_addr = 0;
   int         n_sr = 0;
   int         n_dm = 0;

   always #5 clk = ~clk;

   spi_fsm #(.WORD_BITS(8), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclk_pos  (sclk_pos),
      .sclk_neg  (sclk_neg),
      .cs        (cs),
      .rw_bit    (rw_bit),
      .miso_buff (miso_buff),
      .dm_we     (dm_we),
      .addr_we   (addr_we),
      .sr_we     (sr_we),
      .state     (state)
   );

   // Expected {state, miso_buff, dm_we, addr_we, sr_we} for a given state code
   function automatic int evt(input int s);
      return (s << 4) | ((s == 6) ? 8 : 0) | ((s == 8) ? 4 : 0) |
             ((s == 2) ? 2 : 0) | ((s == 5) ? 1 : 0);
   endfunction

   function automatic int obsVec();
      return int'({state, miso_buff, dm_we, addr_we, sr_we});
   endfunction

   task automatic checkOutput(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: one sample per clock, 1 time unit after the active edge
   always begin
      @(posedge clk);
      #1;
      if (mon_en && state !== prev_state) begin
         checkOutput("sb_event_present", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) checkOutput("sb_transition", obsVec(), exp_q.pop_front());
      end
      prev_state = state;
      n_addr += int'(addr_we);
      n_sr   += int'(sr_we);
      n_dm   += int'(dm_we);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-clock SCLK edge pulse(s) followed by one quiet clock
   task automatic applyStimulus(input logic p, input logic n);
      @(negedge clk);
      sclk_pos = p;
      sclk_neg = n;
      @(negedge clk);
      sclk_pos = 1'b0;
      sclk_neg = 1'b0;
   endtask

   task automatic clearCounts();
      n_addr = 0;
      n_sr = 0;
      n_dm = 0;
   endtask

   task automatic addrPhase(input logic rw);
      rw_bit = rw;
      cs = 1'b0;
      exp_q.push_back(evt(1));
      tick(1);
      checkOutput("get_addr_entry", int'(state), 1);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, i == 2);
         if (i == 4) applyStimulus(1'b0, 1'b1);
      end
      checkOutput("addr_after_7_pos", int'(state), 1);
      exp_q.push_back(evt(2));
      exp_q.push_back(evt(3));
      if (rw) begin
         exp_q.push_back(evt(4));
         exp_q.push_back(evt(5));
         exp_q.push_back(evt(6));
      end else begin
         exp_q.push_back(evt(7));
      end
      applyStimulus(1'b1, 1'b0);
      checkOutput("got_addr", obsVec(), evt(2));
      tick(1);
      checkOutput("decode", obsVec(), evt(3));
      tick(1);
      checkOutput("decode_branch", obsVec(), evt(rw ? 4 : 7));
   endtask

   task automatic writePhase(input logic cs_at_store);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, i == 3);
         if (i == 5) applyStimulus(1'b0, 1'b1);
      end
      checkOutput("wget_after_7_pos", int'(state), 7);
      exp_q.push_back(evt(8));
      if (!cs_at_store) exp_q.push_back(evt(9));
      applyStimulus(1'b1, 1'b0);
      checkOutput("write_store", obsVec(), evt(8));
      if (cs_at_store) begin
         cs = 1'b1;
         exp_q.push_back(evt(0));
         tick(1);
         checkOutput("cs_at_store_idle", obsVec(), evt(0));
      end else begin
         tick(1);
         checkOutput("write_done", obsVec(), evt(9));
         applyStimulus(1'b1, 1'b1);
         checkOutput("done_holds", obsVec(), evt(9));
         cs = 1'b1;
         exp_q.push_back(evt(0));
         tick(1);
         checkOutput("done_to_idle", obsVec(), evt(0));
      end
   endtask

   task automatic readLead();
      tick(1);
      checkOutput("read_load", obsVec(), evt(5));
      tick(1);
      checkOutput("read_shift_entry", obsVec(), evt(6));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tick(2);
      checkOutput("reset_state", obsVec(), evt(0));
      rst_n = 1'b1;
      mon_en = 1'b1;

      // Write transaction ending in DONE
      clearCounts();
      addrPhase(1'b0);
      writePhase(1'b0);
      checkOutput("write_addr_we_clocks", n_addr, 1);
      checkOutput("write_dm_we_clocks", n_dm, 1);
      checkOutput("write_sr_we_clocks", n_sr, 0);

      // Read transaction: miso_buff must span exactly eight falling edges
      clearCounts();
      addrPhase(1'b1);
      readLead();
      for (int i = 0; i < 8; i++) begin
         if (i == 1) applyStimulus(1'b1, 1'b0);
         checkOutput("miso_before_neg", int'(miso_buff), 1);
         if (i == 7) exp_q.push_back(evt(9));
         applyStimulus(i == 4, 1'b1);
      end
      checkOutput("read_done", obsVec(), evt(9));
      cs = 1'b1;
      exp_q.push_back(evt(0));
      tick(1);
      checkOutput("read_to_idle", obsVec(), evt(0));
      checkOutput("read_sr_we_clocks", n_sr, 1);
      checkOutput("read_addr_we_clocks", n_addr, 1);
      checkOutput("read_dm_we_clocks", n_dm, 0);
      checkOutput("sb_drained", exp_q.size(), 0);

      // Abort during address phase, then a full write reusing the counter
      clearCounts();
      cs = 1'b0;
      exp_q.push_back(evt(1));
      tick(1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
      cs = 1'b1;
      exp_q.push_back(evt(0));
      tick(1);
      checkOutput("abort_idle", obsVec(), evt(0));
      checkOutput("abort_no_pulse", n_addr + n_sr + n_dm, 0);
      addrPhase(1'b0);
      writePhase(1'b1);
      checkOutput("cs_store_dm_we_clocks", n_dm, 1);
      checkOutput("sb_drained_2", exp_q.size(), 0);

      // Asynchronous reset in the middle of READ_SHIFT
      addrPhase(1'b1);
      readLead();
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
      mon_en = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", obsVec(), evt(0));
      clearCounts();
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      checkOutput("first_edge_after_reset", obsVec(), evt(1));
      checkOutput("post_reset_no_pulse", n_addr + n_sr + n_dm, 0);
      cs = 1'b1;
      tick(1);
      checkOutput("post_reset_idle", obsVec(), evt(0));

      // Illegal state code recovers to IDLE
      cs = 1'b0;
      force dut.state_q = 4'd12;
      #1;
      checkOutput("illegal_outputs", obsVec(), evt(12));
      release dut.state_q;
      @(posedge clk);
      #1;
      checkOutput("illegal_recover", obsVec(), evt(0));
      cs = 1'b1;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_fsm.md
SPI_FSM -- requirements
Module: spi_fsm

Interface
REQ-001 Parameter WORD_BITS, default 8: SCLK edges per address byte and per data byte.
REQ-002 Parameter CNT_W, default 4: bit-counter width; SHALL satisfy 2^CNT_W > WORD_BITS.
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 sclk_pos  input  1  one-clk pulse on conditioned SCLK rising edge.
REQ-006 sclk_neg  input  1  one-clk pulse on conditioned SCLK falling edge.
REQ-007 cs  input  1  conditioned chip select, active low.
REQ-008 rw_bit  input  1  shift-register parallel-out bit 0; 1 = read, 0 = write.
REQ-009 miso_buff  output  1  MISO tristate enable.
REQ-010 dm_we  output  1  data-memory write enable.
REQ-011 addr_we  output  1  address-latch write enable.
REQ-012 sr_we  output  1  shift-register parallel-load enable.
REQ-013 state  output  4  current state encoding (debug).

Function
REQ-014 Moore machine: all outputs SHALL be decoded from the state register only, with no combinational path from any input.
REQ-015 State encodings: IDLE=0, GET_ADDR=1, GOT_ADDR=2, DECODE=3, READ_WAIT=4, READ_LOAD=5, READ_SHIFT=6, WRITE_GET=7, WRITE_STORE=8, DONE=9; codes 10-15 SHALL go to IDLE on the next clk.
REQ-016 Output decode: addr_we=1 only in GOT_ADDR; sr_we=1 only in READ_LOAD; miso_buff=1 only in READ_SHIFT; dm_we=1 only in WRITE_STORE; all other states drive all outputs 0.
REQ-017 cs=1 sampled in any state SHALL force next state IDLE and counter 0; this has priority over every other transition.
REQ-018 IDLE: if cs=0, go to GET_ADDR with counter=0.
REQ-019 GET_ADDR: each sclk_pos increments counter; a sclk_pos with counter==WORD_BITS-1 goes to GOT_ADDR and clears counter.
REQ-020 GOT_ADDR: lasts exactly 1 clk, then DECODE.
REQ-021 DECODE: lasts exactly 1 clk and samples rw_bit; the 1-clk gap absorbs the shift register's registered-output latency.
REQ-022 DECODE with rw_bit=1 goes to READ_WAIT; with rw_bit=0 goes to WRITE_GET with counter=0.
REQ-023 READ_WAIT: lasts exactly 1 clk (memory read latency), then READ_LOAD.
REQ-024 READ_LOAD: lasts exactly 1 clk, then READ_SHIFT with counter=0.
REQ-025 READ_SHIFT: each sclk_neg increments counter; a sclk_neg with counter==WORD_BITS-1 goes to DONE and clears counter; sclk_pos is ignored.
REQ-026 WRITE_GET: each sclk_pos increments counter; the WORD_BITS-th sclk_pos goes to WRITE_STORE and clears counter; sclk_neg is ignored.
REQ-027 WRITE_STORE: lasts exactly 1 clk, then DONE; dm_we is therefore a single-clk pulse.
REQ-028 DONE: holds until cs=1, then goes to IDLE; further SCLK edges are ignored.
REQ-029 In counting states, simultaneous sclk_pos and sclk_neg SHALL be processed only for the edge that state counts; the other edge is ignored.
REQ-030 Counter SHALL never exceed WORD_BITS-1 and SHALL not wrap.
REQ-031 cs rising in the same clk as WRITE_STORE: dm_we is still asserted for that clk, then the state goes to IDLE.

Reset
REQ-032 rst_n=0 SHALL immediately, independent of clk, set state=IDLE, counter=0, and all four enables to 0.
REQ-033 rst_n deassertion SHALL be honoured on the next posedge clk; the first transition may occur on that edge.
REQ-034 rst_n asserted mid-transaction SHALL abort it with no pending enable pulse afterwards.

Verification
REQ-035 Write: cs=0, 8 sclk_pos with rw_bit=0 at DECODE, 8 more sclk_pos -> addr_we 1 clk in state 2, dm_we exactly 1 clk in state 8, then state 9; cs=1 -> state 0.
REQ-036 Read: cs=0, 8 sclk_pos with rw_bit=1 -> states 2,3,4,5 each 1 clk; sr_we 1 clk; miso_buff high for exactly 8 sclk_neg; then state 9, miso_buff=0.
REQ-037 Abort: cs=1 after 3 sclk_pos in GET_ADDR -> state 0 next clk, counter 0; no addr_we, dm_we, or sr_we pulse.
REQ-038 Async reset: rst_n=0 mid READ_SHIFT between clk edges -> miso_buff=0 and state=0 before the next posedge.
REQ-039 Edge filtering: sclk_neg pulses during GET_ADDR and WRITE_GET and sclk_pos pulses during READ_SHIFT -> counter unchanged.
REQ-040 Illegal state: force state=12 -> state=0 one clk later with all outputs 0.
